// File: rtl/datamem_mmio.sv
`default_nettype none
// ============================================================================
// Module      : datamem_mmio
// Description : Byte-enabled data RAM plus memory-mapped IO block. Address bit
//               IO_BIT selects the IO window: N_IN input ports, N_OUT output
//               ports with readback, and a change-status word that clears on
//               read. Reads have one cycle of latency and are read-first.
//               Optional macro DATAMEM_MMIO_INSYNC_EN adds a two-flop
//               synchronizer on every input port.
// Revision    : 1.0 - initial release
// ============================================================================
module datamem_mmio #(
  parameter int DEPTH_LOG2 = 5,
  parameter int N_IN       = 2,
  parameter int N_OUT      = 3,
  parameter int IO_BIT     = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           addr,
  input  logic [31:0]           datain,
  input  logic [3:0]            be,
  input  logic                  we,
  input  logic                  re,
  input  logic [32*N_IN-1:0]    in_ports,
  output logic [32*N_OUT-1:0]   out_ports,
  output logic [31:0]           dataout,
  output logic                  rd_valid,
  output logic                  in_change
);

  localparam int c_DEPTH = 2 ** DEPTH_LOG2;

  logic [31:0]           r_mem [c_DEPTH];
  logic [31:0]           r_out [N_OUT];
  logic [32*N_IN-1:0]    r_prev;
  logic [N_IN-1:0]       r_chg;
  logic [31:0]           r_dataout;
  logic                  r_rd_valid;
  logic                  r_in_change;

  logic                  w_is_io;
  logic [4:0]            w_k;
  logic [DEPTH_LOG2-1:0] w_ram_idx;
  logic [32*N_IN-1:0]    w_post;
  logic [N_IN-1:0]       w_chg_now;
  logic [N_IN-1:0]       w_chg_next;
  logic                  w_stat_clr;
  logic [31:0]           w_status;
  logic [31:0]           w_rd_data;
  logic                  w_unused_addr;

  assign w_is_io       = addr[IO_BIT];
  assign w_k           = addr[6:2];
  assign w_ram_idx     = addr[DEPTH_LOG2+1:2];
  // Not every address bit participates in decode; fold them away quietly.
  assign w_unused_addr = ^addr;

`ifdef DATAMEM_MMIO_INSYNC_EN
  logic [32*N_IN-1:0] r_sync1;
  logic [32*N_IN-1:0] r_sync2;

  // Two-flop synchronizer on every input port bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_ports;
      r_sync2 <= r_sync1;
    end
  end
  assign w_post = r_sync2;
`else
  assign w_post = in_ports;
`endif

  // Per-port change detect against the previous cycle's post-sync value.
  generate
    for (genvar p = 0; p < N_IN; p++) begin : g_chg
      assign w_chg_now[p] = (w_post[32*p +: 32] != r_prev[32*p +: 32]);
    end
  endgenerate

  // Status read clears all bits, but a change seen in the same cycle wins.
  assign w_stat_clr = re && w_is_io && (w_k == 5'd31);
  assign w_chg_next = (w_stat_clr ? '0 : r_chg) | w_chg_now;

  // Status word: change bits in the low positions, zero above.
  always_comb begin
    w_status           = '0;
    w_status[N_IN-1:0] = r_chg;
  end

  // Read mux: RAM word or IO register selected by index k.
  always_comb begin
    w_rd_data = '0;
    if (!w_is_io) begin
      w_rd_data = r_mem[w_ram_idx];
    end else begin
      if (w_k == 5'd31) w_rd_data = w_status;
      for (int p = 0; p < N_IN; p++) begin
        if (w_k == 5'(p)) w_rd_data = w_post[32*p +: 32];
      end
      for (int p = 0; p < N_OUT; p++) begin
        if (w_k == 5'(p + 16)) w_rd_data = r_out[p];
      end
    end
  end

  // RAM byte-lane writes; contents survive reset, but reset blocks writes.
  always_ff @(posedge clock) begin
    if (!reset && we && !w_is_io) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) r_mem[w_ram_idx][8*b +: 8] <= datain[8*b +: 8];
      end
    end
  end

  // Output port registers with byte-lane writes; out-of-range k is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int p = 0; p < N_OUT; p++) r_out[p] <= '0;
    end else if (we && w_is_io) begin
      for (int p = 0; p < N_OUT; p++) begin
        for (int b = 0; b < 4; b++) begin
          if (w_k == 5'(p) && be[b]) r_out[p][8*b +: 8] <= datain[8*b +: 8];
        end
      end
    end
  end

  // Change tracking state and the registered summary flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev      <= '0;
      r_chg       <= '0;
      r_in_change <= 1'b0;
    end else begin
      r_prev      <= w_post;
      r_chg       <= w_chg_next;
      r_in_change <= |w_chg_next;
    end
  end

  // One-cycle read pipeline; dataout holds between reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_dataout  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= re;
      if (re) r_dataout <= w_rd_data;
    end
  end

  generate
    for (genvar p = 0; p < N_OUT; p++) begin : g_out
      assign out_ports[32*p +: 32] = r_out[p];
    end
  endgenerate

  assign dataout   = r_dataout;
  assign rd_valid  = r_rd_valid;
  assign in_change = r_in_change;

endmodule
`default_nettype wire

// File: doc/datamem_mmio.md
DATAMEM_MMIO -- requirements
Module: datamem_mmio

Interface
REQ-001 Parameter DEPTH_LOG2, default 5, sets data RAM depth to 2**DEPTH_LOG2 32-bit words; legal range 2..(IO_BIT-2).
REQ-002 Parameter N_IN, default 2, is the number of 32-bit input ports; legal range 1..16.
REQ-003 Parameter N_OUT, default 3, is the number of 32-bit output ports; legal range 1..15.
REQ-004 Parameter IO_BIT, default 7, is the address bit that selects IO (1) or RAM (0); minimum 7.
REQ-005 Ports SHALL be as follows; one clock; reset is synchronous and active-high:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  byte address; addr[1:0] ignored.
- datain  in  32  write data.
- be  in  4  byte-lane write enables; be[i] covers datain[8i+7:8i].
- we  in  1  write request.
- re  in  1  read request.
- in_ports  in  32*N_IN  input port p on bits [32p+31:32p].
- out_ports  out  32*N_OUT  output port p on bits [32p+31:32p].
- dataout  out  32  read data.
- rd_valid  out  1  dataout valid this cycle.
- in_change  out  1  OR of all status change bits.

Function
REQ-006 Decode: addr[IO_BIT]=0 SHALL select RAM word addr[DEPTH_LOG2+1:2]; addr[IO_BIT]=1 SHALL select IO index k=addr[6:2].
REQ-007 RAM write: when we=1, each lane with be[i]=1 SHALL be written at the clock edge; lanes with be[i]=0 SHALL be unchanged.
REQ-008 IO write, k<N_OUT: out port k SHALL be updated per byte lane as in REQ-007 and SHALL drive out_ports from the following cycle.
REQ-009 IO writes with k>=N_OUT SHALL be ignored, with no side effect.
REQ-010 Read latency SHALL be one cycle: re=1 in cycle n gives rd_valid=1 and dataout in cycle n+1; rd_valid=0 otherwise.
REQ-011 While rd_valid=0, dataout SHALL hold its last value.
REQ-012 Read map:
- RAM word.
- k<N_IN: input port k (post-sync value).
- 16<=k<16+N_OUT: readback of out port k-16.
- k=31: status word, bit p = change bit of input port p, upper bits 0.
- all other k: 32'h0.
REQ-013 Simultaneous we and re to the same location SHALL return the pre-write data (read-first); the write SHALL still take effect.
REQ-014 Change detection: a prev register per input port SHALL hold the previous cycle's post-sync value; change bit p SHALL set in any cycle where post-sync value p differs from prev p.
REQ-015 A read of k=31 SHALL clear all change bits at that edge, except that a change detected in the same cycle SHALL leave its bit set (set wins).
REQ-016 in_change SHALL be registered and SHALL equal the OR of the change bits.

Reset
REQ-017 reset=1 at an edge SHALL clear out_ports, dataout, rd_valid, change bits, prev registers and sync flops to 0; RAM contents SHALL NOT be cleared.
REQ-018 reset SHALL override we and re in the same cycle; a read issued in the cycle before reset SHALL NOT produce rd_valid after reset.

Configuration
REQ-019 With DATAMEM_MMIO_INSYNC_EN defined, each input port SHALL pass through a two-flop synchronizer; the post-sync value then lags in_ports by 2 cycles.
REQ-020 Without DATAMEM_MMIO_INSYNC_EN, post-sync value SHALL equal in_ports directly, with no added latency; REQ-014/015 are unchanged.

Verification
REQ-021 Write 32'hDEADBEEF to addr 0x10 with be=4'hF, then re at 0x10 -> rd_valid=1 next cycle and dataout=32'hDEADBEEF.
REQ-022 Write 32'h11223344 with be=4'b0101 over a word holding 32'hFFFFFFFF -> read returns 32'hFF22FF44.
REQ-023 Write 32'hA5 to addr 0x84 (IO k=1) -> out port 1 = 32'hA5 next cycle; read at 0xC4 (k=17) returns 32'hA5; write to k=5 leaves all out ports unchanged.
REQ-024 in_ports port 0 changes 0->7 -> in_change=1 after the sync latency (+1); read at 0xFC returns 32'h1 and clears it; a port-1 change in the same cycle as the read leaves status bit 1 set.
REQ-025 Same-cycle we+re to 0x08 (old 32'h1, new 32'h2) -> dataout=32'h1; next read returns 32'h2.
REQ-026 Assert reset with out ports nonzero and a read pending -> all outputs 0, rd_valid=0, and previously written RAM data still readable.
